// File: rtl/exu_bht_upd_q_pkg.sv
// Shared constants and types for the BHT update queue.
package exu_bht_upd_q_pkg;

  localparam int unsigned BHT_IDX_W = 8;

  typedef enum logic [1:0] {
    PUSH_NONE,
    PUSH_COALESCE,
    PUSH_NORMAL,
    PUSH_DROP
  } push_kind_e;

endpackage

// File: rtl/exu_bht_upd_q.sv
// Buffers resolved-branch BHT updates, coalesces repeats to the newest entry,
// and drains the head entry into the shared BHT write port.
module exu_bht_upd_q
  import exu_bht_upd_q_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = BHT_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     upd_valid,
  input  logic [IDX_W-1:0]         upd_index,
  input  logic [1:0]               upd_hist,
  input  logic                     upd_misp,
  input  logic                     flush_q,
  input  logic                     bht_wr_ready,
  output logic                     bht_wr_valid,
  output logic [IDX_W-1:0]         bht_wr_index,
  output logic [1:0]               bht_wr_hist,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     misp_pending,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic             misp;
    logic [1:0]       hist;
    logic [IDX_W-1:0] index;
  } bht_upd_pkt_t;

  bht_upd_pkt_t     entry_q [DEPTH];
  bht_upd_pkt_t     entry_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  push_kind_e       push_kind;
  logic [PW-1:0]    tail_ptr;
  logic             wr_valid;
  logic             pop;
  logic [PW-1:0]    occ_off;
  logic             misp_acc;

  always_comb begin
    entry_d    = entry_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    push_kind  = PUSH_NONE;

    tail_ptr = wr_ptr_q - PW'(1);
    wr_valid = (count_q != '0) && !flush_q;
    pop      = wr_valid && bht_wr_ready;

    // The newest entry is only being popped when it is also the head.
    if (upd_valid && !flush_q) begin
      if ((count_q != '0) && (entry_q[tail_ptr].index == upd_index) &&
          !(pop && (count_q == CW'(1)))) begin
        push_kind = PUSH_COALESCE;
      end else if ((count_q != CW'(DEPTH)) || pop) begin
        push_kind = PUSH_NORMAL;
      end else begin
        push_kind = PUSH_DROP;
      end
    end

    if (flush_q) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case (push_kind)
        PUSH_COALESCE: begin
          entry_d[tail_ptr].hist = upd_hist;
          entry_d[tail_ptr].misp = entry_q[tail_ptr].misp | upd_misp;
        end
        PUSH_NORMAL: begin
          entry_d[wr_ptr_q] = '{misp: upd_misp, hist: upd_hist, index: upd_index};
          wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        PUSH_DROP: begin
          entry_d[wr_ptr_q] = '{misp: upd_misp, hist: upd_hist, index: upd_index};
          wr_ptr_d          = wr_ptr_q + PW'(1);
          rd_ptr_d          = rd_ptr_q + PW'(1);
          overflow_d        = 1'b1;
        end
        default: ;
      endcase
      if ((push_kind == PUSH_NORMAL) && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && (push_kind != PUSH_NORMAL)) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // An entry is occupied when its distance from the head is below count.
  always_comb begin
    misp_acc = 1'b0;
    occ_off  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_off = PW'(i) - rd_ptr_q;
      if (({1'b0, occ_off} < count_q) && entry_q[i].misp) begin
        misp_acc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      entry_q    <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bht_wr_valid = wr_valid;
  assign bht_wr_index = entry_q[rd_ptr_q].index;
  assign bht_wr_hist  = entry_q[rd_ptr_q].hist;
  assign q_count      = count_q;
  assign misp_pending = misp_acc;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_exu_bht_upd_q.sv
// Bench for exu_bht_upd_q: directed scenarios plus randomized traffic against a queue model.
module tb_exu_bht_upd_q;

  localparam int DEPTH = 4;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst_l;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic [1:0]       upd_hist;
  logic             upd_misp;
  logic             flush_q;
  logic             bht_wr_ready;
  logic             bht_wr_valid;
  logic [IDX_W-1:0] bht_wr_index;
  logic [1:0]       bht_wr_hist;
  logic [2:0]       q_count;
  logic             misp_pending;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit       misp;
    bit [1:0] hist;
    bit [7:0] idx;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;

  always #5 clk = ~clk;

  exu_bht_upd_q #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .upd_valid    (upd_valid),
    .upd_index    (upd_index),
    .upd_hist     (upd_hist),
    .upd_misp     (upd_misp),
    .flush_q      (flush_q),
    .bht_wr_ready (bht_wr_ready),
    .bht_wr_valid (bht_wr_valid),
    .bht_wr_index (bht_wr_index),
    .bht_wr_hist  (bht_wr_hist),
    .q_count      (q_count),
    .misp_pending (misp_pending),
    .overflow     (overflow)
  );

  function automatic bit m_misp();
    bit r = 1'b0;
    foreach (mq[i]) r |= mq[i].misp;
    return r;
  endfunction

  task automatic model_update(bit v, bit [7:0] idx, bit [1:0] h, bit m, bit fl, bit rdy);
    bit   pop;
    ent_t t;
    int   n;
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      n   = mq.size();
      pop = (n > 0) && rdy;
      if (v && (n > 0) && (mq[n-1].idx == idx) && !(pop && n == 1)) begin
        t = mq[n-1];
        t.hist = h;
        t.misp = t.misp | m;
        mq[n-1] = t;
        if (pop) void'(mq.pop_front());
      end else begin
        if (pop) void'(mq.pop_front());
        if (v) begin
          if (mq.size() == DEPTH) begin
            void'(mq.pop_front());
            m_ovf = 1'b1;
          end
          t.misp = m;
          t.hist = h;
          t.idx  = idx;
          mq.push_back(t);
        end
      end
    end
  endtask

  task automatic set_in(bit v, bit [7:0] idx, bit [1:0] h, bit m, bit fl, bit rdy);
    upd_valid    = v;
    upd_index    = idx;
    upd_hist     = h;
    upd_misp     = m;
    flush_q      = fl;
    bht_wr_ready = rdy;
    #2;
  endtask

  task automatic tick();
    bit       v   = upd_valid;
    bit [7:0] idx = upd_index;
    bit [1:0] h   = upd_hist;
    bit       m   = upd_misp;
    bit       fl  = flush_q;
    bit       rdy = bht_wr_ready;
    @(posedge clk);
    model_update(v, idx, h, m, fl, rdy);
    #1;
    upd_valid = 1'b0;
    flush_q   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    upd_valid = 0; upd_index = '0; upd_hist = '0; upd_misp = 0; flush_q = 0; bht_wr_ready = 0;
    mq.delete();
    m_ovf = 1'b0;
    #12;
    checks++; if (bht_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bht_wr_valid); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", q_count); end
    checks++; if (misp_pending !== 1'b0) begin errors++; $display("FAIL reset_misp got=%0b exp=0", misp_pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_push();
    set_in(1, 8'h12, 2'b10, 0, 0, 0);
    checks++; if (bht_wr_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got=%0b exp=0", bht_wr_valid); end
    tick();
    checks++; if (bht_wr_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", bht_wr_valid); end
    checks++; if (bht_wr_index !== 8'h12) begin errors++; $display("FAIL single_index got=%h exp=12", bht_wr_index); end
    checks++; if (bht_wr_hist !== 2'b10) begin errors++; $display("FAIL single_hist got=%b exp=10", bht_wr_hist); end
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", q_count); end
    set_in(0, 8'h00, 2'b00, 0, 0, 1);
    tick();
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", q_count); end
  endtask

  task automatic test_coalesce();
    set_in(1, 8'h05, 2'b01, 0, 0, 0); tick();
    set_in(1, 8'h05, 2'b11, 1, 0, 0); tick();
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL coal_count got=%0d exp=1", q_count); end
    checks++; if (bht_wr_hist !== 2'b11) begin errors++; $display("FAIL coal_hist got=%b exp=11", bht_wr_hist); end
    checks++; if (misp_pending !== 1'b1) begin errors++; $display("FAIL coal_misp got=%0b exp=1", misp_pending); end
    set_in(0, 8'h00, 2'b00, 0, 0, 1); tick();
    checks++; if (misp_pending !== 1'b0) begin errors++; $display("FAIL coal_misp_after_pop got=%0b exp=0", misp_pending); end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) begin
      set_in(1, 8'(k), 2'(k), 0, 0, 0);
      tick();
    end
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", q_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    checks++; if (bht_wr_index !== 8'h02) begin errors++; $display("FAIL ovf_head got=%h exp=02", bht_wr_index); end
    for (int k = 0; k < 4; k++) begin
      set_in(0, 8'h00, 2'b00, 0, 0, 1);
      checks++;
      if (bht_wr_valid !== 1'b1 || bht_wr_index !== 8'(k + 2)) begin
        errors++;
        $display("FAIL ovf_drain%0d got=v%0b/%h exp=v1/%h", k, bht_wr_valid, bht_wr_index, 8'(k + 2));
      end
      tick();
    end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL ovf_drained got=%0d exp=0", q_count); end
  endtask

  task automatic test_no_coalesce_on_pop();
    set_in(1, 8'h07, 2'b01, 0, 0, 0); tick();
    set_in(1, 8'h07, 2'b10, 0, 0, 1); tick();
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL nocoal_count got=%0d exp=1", q_count); end
    checks++; if (bht_wr_valid !== 1'b1 || bht_wr_index !== 8'h07) begin errors++; $display("FAIL nocoal_head got=v%0b/%h exp=v1/07", bht_wr_valid, bht_wr_index); end
    checks++; if (bht_wr_hist !== 2'b10) begin errors++; $display("FAIL nocoal_hist got=%b exp=10", bht_wr_hist); end
  endtask

  task automatic test_flush();
    set_in(1, 8'h20, 2'b00, 0, 0, 0); tick();
    set_in(1, 8'h21, 2'b01, 1, 0, 0); tick();
    checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", q_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf got=%0b exp=1", overflow); end
    set_in(1, 8'h22, 2'b11, 1, 1, 1);
    checks++; if (bht_wr_valid !== 1'b0) begin errors++; $display("FAIL flush_gate got=%0b exp=0", bht_wr_valid); end
    tick();
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", q_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got=%0b exp=0", overflow); end
    checks++; if (bht_wr_valid !== 1'b0 || misp_pending !== 1'b0) begin errors++; $display("FAIL flush_empty got=v%0b/m%0b exp=v0/m0", bht_wr_valid, misp_pending); end
  endtask

  task automatic test_random();
    bit       v, m, fl, rdy, ev;
    bit [7:0] idx;
    bit [1:0] h;
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      idx = 8'($urandom_range(0, 3));
      h   = 2'($urandom);
      m   = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 40) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      set_in(v, idx, h, m, fl, rdy);
      ev = (mq.size() != 0) && !fl;
      checks++; if (bht_wr_valid !== ev) begin errors++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, bht_wr_valid, ev); end
      if (ev) begin
        checks++;
        if (bht_wr_index !== mq[0].idx || bht_wr_hist !== mq[0].hist) begin
          errors++;
          $display("FAIL rnd_head c=%0d got=%h/%b exp=%h/%b", c, bht_wr_index, bht_wr_hist, mq[0].idx, mq[0].hist);
        end
      end
      checks++; if (q_count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, q_count, mq.size()); end
      checks++; if (misp_pending !== m_misp()) begin errors++; $display("FAIL rnd_misp c=%0d got=%0b exp=%0b", c, misp_pending, m_misp()); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c=%0d got=%0b exp=%0b", c, overflow, m_ovf); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    set_in(0, 8'h00, 2'b00, 0, 1, 0); tick();
    for (int k = 0; k < 5; k++) begin
      set_in(1, 8'(8'h30 + k), 2'b11, 1, 0, 0); tick();
    end
    checks++; if (q_count !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL arst_pre got=%0d/o%0b exp=4/o1", q_count, overflow); end
    #1;
    rst_l = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    checks++; if (bht_wr_valid !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL arst_vc got=v%0b/%0d exp=v0/0", bht_wr_valid, q_count); end
    checks++; if (misp_pending !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL arst_mo got=m%0b/o%0b exp=m0/o0", misp_pending, overflow); end
    checks++; if (bht_wr_index !== 8'h00 || bht_wr_hist !== 2'b00) begin errors++; $display("FAIL arst_entry got=%h/%b exp=00/00", bht_wr_index, bht_wr_hist); end
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_coalesce();
    test_overflow();
    test_no_coalesce_on_pop();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
